// File: rtl/gpioemu_bus_master.sv
// gpioemu_bus_master: upstream sequencer for the gpioemu multiplier peripheral.
// It takes one 24x24 operand pair, runs the peripheral through a fixed
// write/start/poll/read sequence of 3-cycle bus accesses, and returns one result record.
// Optional macro GPIOEMU_POPCHK_EN adds a local popcount cross-check of W against L.
//
// state  | meaning
// IDLE   | ready for an operand pair
// WR_A1  | writing operand A
// WR_A2  | writing operand B
// WR_GO  | writing the start bit to the control register
// WAIT   | idle gap before the first status poll
// POLL   | reading status until done or out of polls
// RD_W   | reading product low word
// RD_L   | reading popcount
// OUT    | result record presented, waiting for res_ready
module gpioemu_bus_master #(
    parameter logic [15:0] ADDR_A1  = 16'h0380,
    parameter logic [15:0] ADDR_A2  = 16'h0388,
    parameter logic [15:0] ADDR_W   = 16'h0390,
    parameter logic [15:0] ADDR_L   = 16'h0398,
    parameter logic [15:0] ADDR_CS  = 16'h03A0,
    parameter int          GO_WAIT  = 2,
    parameter int          POLL_MAX = 1023
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [23:0] op_a,
    input  logic [23:0] op_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_w,
    output logic [5:0]  res_ones,
    output logic        res_ovf,
    output logic        res_timeout,
    output logic        res_mismatch,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int WW = $clog2(GO_WAIT + 1);
    localparam int PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_WAIT, S_POLL, S_RD_W, S_RD_L, S_OUT
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

    state_t        state, state_nxt;
    phase_t        phase, phase_nxt;
    logic [WW-1:0] wait_cnt;
    logic [PW-1:0] poll_cnt;
    logic [23:0]   op_a_q, op_b_q;
    logic          acc_active, acc_wr, acc_last, hs_in;
    logic [15:0]   acc_addr;
    logic [31:0]   acc_data;
    // Status bit 1 is "done"; bit 0 is "product fits in 32 bits", so done with
    // bit 0 low is a finished, overflowed result rather than a pending one.
    logic          st_done;

    assign st_done   = sdata_in[1];
    assign acc_last  = (phase == PH_HOLD);
    assign hs_in     = op_valid && (state == S_IDLE);
    assign op_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_OUT);
    assign saddress  = acc_addr;
    assign sdata_out = acc_data;
    assign swr       = acc_active &&  acc_wr && (phase == PH_STROBE);
    assign srd       = acc_active && !acc_wr && (phase == PH_STROBE);

    // State and bus-phase registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= S_IDLE;
            phase <= PH_SETUP;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Next state, current bus access and phase sequencing.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = PH_SETUP;
        acc_active = 1'b0;
        acc_wr     = 1'b0;
        acc_addr   = '0;
        acc_data   = '0;
        case (state)
            S_IDLE:  if (op_valid) state_nxt = S_WR_A1;
            S_WR_A1: begin
                acc_active = 1'b1; acc_wr = 1'b1;
                acc_addr = ADDR_A1; acc_data = {8'h00, op_a_q};
                if (acc_last) state_nxt = S_WR_A2;
            end
            S_WR_A2: begin
                acc_active = 1'b1; acc_wr = 1'b1;
                acc_addr = ADDR_A2; acc_data = {8'h00, op_b_q};
                if (acc_last) state_nxt = S_WR_GO;
            end
            S_WR_GO: begin
                acc_active = 1'b1; acc_wr = 1'b1;
                acc_addr = ADDR_CS; acc_data = 32'h1;
                if (acc_last) state_nxt = S_WAIT;
            end
            S_WAIT:  if (wait_cnt == WW'(1)) state_nxt = S_POLL;
            S_POLL: begin
                acc_active = 1'b1; acc_addr = ADDR_CS;
                if (acc_last) begin
                    if (st_done)                  state_nxt = S_RD_W;
                    else if (poll_cnt == PW'(1))  state_nxt = S_OUT;
                end
            end
            S_RD_W: begin
                acc_active = 1'b1; acc_addr = ADDR_W;
                if (acc_last) state_nxt = S_RD_L;
            end
            S_RD_L: begin
                acc_active = 1'b1; acc_addr = ADDR_L;
                if (acc_last) state_nxt = S_OUT;
            end
            S_OUT:   if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (acc_active) begin
            case (phase)
                PH_SETUP:  phase_nxt = PH_STROBE;
                PH_STROBE: phase_nxt = PH_HOLD;
                default:   phase_nxt = PH_SETUP;
            endcase
        end
    end

    // Operand capture, wait/poll down-counters, result fields and op counter.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            op_a_q      <= '0;
            op_b_q      <= '0;
            wait_cnt    <= '0;
            poll_cnt    <= '0;
            res_w       <= '0;
            res_ones    <= '0;
            res_ovf     <= 1'b0;
            res_timeout <= 1'b0;
            op_count    <= '0;
        end else begin
            if (hs_in) begin
                op_a_q      <= op_a;
                op_b_q      <= op_b;
                res_w       <= '0;
                res_ones    <= '0;
                res_ovf     <= 1'b0;
                res_timeout <= 1'b0;
            end
            if (state == S_WR_GO && acc_last) begin
                wait_cnt <= WW'(GO_WAIT);
                poll_cnt <= PW'(POLL_MAX);
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt - WW'(1);
            if (state == S_POLL && acc_last) begin
                if (st_done) begin
                    res_ovf <= ~sdata_in[0];
                end else begin
                    poll_cnt <= poll_cnt - PW'(1);
                    if (poll_cnt == PW'(1)) res_timeout <= 1'b1;
                end
            end
            if (state == S_RD_W && acc_last) res_w    <= sdata_in;
            if (state == S_RD_L && acc_last) res_ones <= sdata_in[5:0];
            if (state == S_OUT && res_ready) op_count <= op_count + 16'd1;
        end
    end

`ifdef GPIOEMU_POPCHK_EN
    function automatic logic [5:0] pop32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

    // Cross-check the peripheral's popcount against the product word just read.
    // A timed-out op never reaches RD_L, so its flag stays cleared.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            res_mismatch <= 1'b0;
        end else if (hs_in) begin
            res_mismatch <= 1'b0;
        end else if (state == S_RD_L && acc_last) begin
            res_mismatch <= (pop32(res_w) != sdata_in[5:0]);
        end
    end
`else
    assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_gpioemu_bus_master.sv
// Testbench for gpioemu_bus_master with a behavioural multiplier peripheral.
module tb_gpioemu_bus_master;

    localparam logic [15:0] A_A1 = 16'h0380;
    localparam logic [15:0] A_A2 = 16'h0388;
    localparam logic [15:0] A_W  = 16'h0390;
    localparam logic [15:0] A_L  = 16'h0398;
    localparam logic [15:0] A_CS = 16'h03A0;
    localparam int          PMAX = 4;
`ifdef GPIOEMU_POPCHK_EN
    localparam bit POPCHK = 1'b1;
`else
    localparam bit POPCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [23:0] op_a = '0;
    logic [23:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_w;
    logic [5:0]  res_ones;
    logic        res_ovf, res_timeout, res_mismatch;
    logic [15:0] saddress;
    logic        swr, srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;
    logic        busy;
    logic [15:0] op_count;

    gpioemu_bus_master #(.POLL_MAX(PMAX)) dut (
        .clk(clk), .n_reset(n_reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_w(res_w), .res_ones(res_ones), .res_ovf(res_ovf),
        .res_timeout(res_timeout), .res_mismatch(res_mismatch),
        .saddress(saddress), .swr(swr), .srd(srd),
        .sdata_out(sdata_out), .sdata_in(sdata_in),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Peripheral model: registers written on swr, counts reads, product on start.
    logic        clr = 1'b0;
    int          cfg_done_after = 1;
    bit          cfg_force = 1'b0;
    logic [31:0] cfg_w = '0;
    logic [5:0]  cfg_l = '0;
    logic [23:0] m_a1 = '0, m_a2 = '0;
    logic [47:0] m_prod = '0;
    logic        m_started = 1'b0;
    logic [31:0] m_cs_data = '0;
    int          m_polls = 0, m_rd_w = 0, m_rd_l = 0, m_wr_cs = 0;
    logic        m_done;
    bit          both_strobes = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            m_started <= 1'b0; m_polls <= 0; m_rd_w <= 0; m_rd_l <= 0;
            m_wr_cs <= 0; m_a1 <= '0; m_a2 <= '0; m_prod <= '0; m_cs_data <= '0;
        end else begin
            if (swr) begin
                case (saddress)
                    A_A1: m_a1 <= sdata_out[23:0];
                    A_A2: m_a2 <= sdata_out[23:0];
                    A_CS: begin
                        m_wr_cs   <= m_wr_cs + 1;
                        m_cs_data <= sdata_out;
                        if (sdata_out[0]) begin
                            m_started <= 1'b1;
                            m_polls   <= 0;
                            m_prod    <= {24'h0, m_a1} * {24'h0, m_a2};
                        end
                    end
                    default: ;
                endcase
            end
            if (srd) begin
                case (saddress)
                    A_CS:    m_polls <= m_polls + 1;
                    A_W:     m_rd_w  <= m_rd_w + 1;
                    A_L:     m_rd_l  <= m_rd_l + 1;
                    default: ;
                endcase
            end
        end
    end

    assign m_done = m_started && (cfg_done_after > 0) && (m_polls >= cfg_done_after);

    // L carries junk in bits above [5:0] so the master must ignore them.
    always_comb begin
        sdata_in = '0;
        case (saddress)
            A_CS: sdata_in = {30'h0, m_done, (m_prod[47:32] == 16'h0)};
            A_W:  sdata_in = cfg_force ? cfg_w : m_prod[31:0];
            A_L:  sdata_in = cfg_force ? {26'h0, cfg_l}
                                       : {8'h00, 18'h15555, 6'($countones(m_prod[31:0]))};
            default: sdata_in = '0;
        endcase
    end

    always @(negedge clk) if (swr && srd) both_strobes <= 1'b1;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_model();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Handshake one op and return the cycle (1 = first after handshake edge) res_valid rose.
    task automatic do_op(input logic [23:0] a, input logic [23:0] b, output int cyc);
        @(negedge clk);
        op_a = a; op_b = b; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt++;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("op_ready_after_accept", 32'(op_ready), 32'd1);
    endtask

    typedef struct {
        logic [23:0] a, b;
        int          done_after;
        logic [31:0] w;
        logic [5:0]  ones;
        logic        ovf, tmo;
        int          polls;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int cyc;
        logic [31:0] snap_w;
        logic [5:0]  snap_ones;
        logic [2:0]  snap_flags;
        bit          stable, rdy_low, found;

        // done_after = 0 means status stays 2'b01 forever
        vecs[0] = '{24'h000003, 24'h000005, 1, 32'h0000000F, 6'd4,  1'b0, 1'b0, 1, 21};
        vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 1, 32'hFE000001, 6'd8,  1'b1, 1'b0, 1, 21};
        vecs[2] = '{24'h000000, 24'h123456, 2, 32'h00000000, 6'd0,  1'b0, 1'b0, 2, 24};
        vecs[3] = '{24'h001000, 24'h010000, 3, 32'h10000000, 6'd1,  1'b0, 1'b0, 3, 27};
        vecs[4] = '{24'h010000, 24'h010000, 4, 32'h00000000, 6'd0,  1'b1, 1'b0, 4, 30};
        vecs[5] = '{24'h00FFFF, 24'h010001, 1, 32'hFFFFFFFF, 6'd32, 1'b0, 1'b0, 1, 21};
        vecs[6] = '{24'h000007, 24'h000009, 0, 32'h00000000, 6'd0,  1'b0, 1'b1, 4, 24};

        @(negedge clk); @(negedge clk);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_strobes", {30'h0, swr, srd}, 32'd0);
        chk("rst_saddress", 32'(saddress), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_res", {res_w[15:0], 10'h0, res_ones}, 32'd0);
        n_reset = 1'b1;

        foreach (vecs[i]) begin
            cfg_done_after = vecs[i].done_after;
            clr_model();
            do_op(vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].lat));
            chk($sformatf("v%0d_res_w", i), res_w, vecs[i].w);
            chk($sformatf("v%0d_res_ones", i), 32'(res_ones), 32'(vecs[i].ones));
            chk($sformatf("v%0d_res_ovf", i), 32'(res_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_res_timeout", i), 32'(res_timeout), 32'(vecs[i].tmo));
            chk($sformatf("v%0d_res_mismatch", i), 32'(res_mismatch), 32'd0);
            chk($sformatf("v%0d_polls", i), 32'(m_polls), 32'(vecs[i].polls));
            chk($sformatf("v%0d_rd_w", i), 32'(m_rd_w), vecs[i].tmo ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_rd_l", i), 32'(m_rd_l), vecs[i].tmo ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_wr_a1", i), 32'(m_a1), 32'(vecs[i].a));
            chk($sformatf("v%0d_wr_a2", i), 32'(m_a2), 32'(vecs[i].b));
            chk($sformatf("v%0d_wr_cs", i), m_cs_data, 32'h1);
            chk($sformatf("v%0d_wr_cs_n", i), 32'(m_wr_cs), 32'd1);
            accept();
        end

        // Back-pressure: hold res_ready low for 10 cycles in OUT, try to sneak an op in.
        cfg_done_after = 1;
        clr_model();
        do_op(24'h000003, 24'h000005, cyc);
        snap_w = res_w; snap_ones = res_ones;
        snap_flags = {res_ovf, res_timeout, res_mismatch};
        stable = 1'b1; rdy_low = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin op_valid = 1'b1; op_a = 24'h0000AA; op_b = 24'h0000BB; end
            if (k == 5) op_valid = 1'b0;
            @(negedge clk);
            if (!res_valid || res_w !== snap_w || res_ones !== snap_ones ||
                {res_ovf, res_timeout, res_mismatch} !== snap_flags) stable = 1'b0;
            if (op_ready) rdy_low = 1'b0;
        end
        chk("hold_fields_stable", 32'(stable), 32'd1);
        chk("hold_op_ready_low", 32'(rdy_low), 32'd1);
        chk("hold_res_w", res_w, 32'h0000000F);
        accept();
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("hold_no_buffered_op", 32'(busy), 32'd0);
        chk("hold_no_extra_write", 32'(m_wr_cs), 32'd1);

        // Peripheral popcount disagreeing with its own W.
        cfg_force = 1'b1; cfg_w = 32'h7; cfg_l = 6'd5;
        clr_model();
        do_op(24'h000002, 24'h000003, cyc);
        chk("force_res_w", res_w, 32'h7);
        chk("force_res_ones", 32'(res_ones), 32'd5);
        chk("force_mismatch", 32'(res_mismatch), 32'(POPCHK));
        accept();
        cfg_force = 1'b0;
        clr_model();
        do_op(24'h000003, 24'h000005, cyc);
        chk("after_force_mismatch", 32'(res_mismatch), 32'd0);
        chk("after_force_res_w", res_w, 32'h0000000F);
        accept();

        // Reset in the middle of the operand B write strobe.
        clr_model();
        @(negedge clk);
        op_a = 24'h000005; op_b = 24'h000006; op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (swr && saddress == A_A2) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_found_strobe", 32'(found), 32'd1);
        n_reset = 1'b0;
        #1;
        chk("rst_mid_swr", 32'(swr), 32'd0);
        chk("rst_mid_saddress", 32'(saddress), 32'd0);
        chk("rst_mid_sdata_out", sdata_out, 32'd0);
        chk("rst_mid_op_ready", 32'(op_ready), 32'd1);
        chk("rst_mid_op_count", 32'(op_count), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        n_reset = 1'b1;
        clr_model();
        do_op(24'h000004, 24'h000006, cyc);
        chk("post_rst_latency", 32'(cyc), 32'd21);
        chk("post_rst_res_w", res_w, 32'd24);
        chk("post_rst_res_ones", 32'(res_ones), 32'd2);
        accept();

        chk("strobes_never_together", 32'(both_strobes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
